// File: rtl/gearbox_pkg.sv
// Shared constants and helpers for the Interlaken 67-bit receive gearbox.
package gearbox_pkg;

    localparam int unsigned WORD_W = 67;

    localparam logic [1:0] HDR_DATA = 2'b01;
    localparam logic [1:0] HDR_CTRL = 2'b10;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCK   = 2'd2
    } state_e;

    function automatic logic hdr_valid(input logic [1:0] hdr);
        return (hdr == HDR_DATA) || (hdr == HDR_CTRL);
    endfunction

endpackage

// File: rtl/word_lock_fsm.sv
// Word-lock state machine: sync-header hunt, lock verification and error-window monitoring.
module word_lock_fsm
    import gearbox_pkg::*;
#(
    parameter int unsigned GOOD_CNT  = 64,
    parameter int unsigned WINDOW    = 64,
    parameter int unsigned BAD_LIMIT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic cand_valid_i,
    input  logic hdr_ok_i,
    output logic slip_o,
    output logic locked_o
);

    localparam int unsigned GoodW = $clog2(GOOD_CNT + 1);
    localparam int unsigned WinW  = $clog2(WINDOW + 1);
    localparam int unsigned BadW  = $clog2(BAD_LIMIT + 1);

    localparam logic [GoodW-1:0] GoodLast = GoodW'(GOOD_CNT - 1);
    localparam logic [WinW-1:0]  WinLast  = WinW'(WINDOW - 1);
    localparam logic [BadW-1:0]  BadLast  = BadW'(BAD_LIMIT - 1);

    state_e           state_q;
    logic [GoodW-1:0] good_q;
    logic [WinW-1:0]  win_q;
    logic [BadW-1:0]  bad_q;
    logic             locked_q;

    // Slip must act on the same candidate, so it is decoded from the current state.
    always_comb begin
        slip_o = 1'b0;
        if (cand_valid_i && !hdr_ok_i) begin
            slip_o = (state_q != ST_LOCK) || (bad_q == BadLast);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_HUNT;
            good_q   <= '0;
            win_q    <= '0;
            bad_q    <= '0;
            locked_q <= 1'b0;
        end else if (cand_valid_i) begin
            unique case (state_q)
                ST_HUNT: begin
                    if (hdr_ok_i) begin
                        win_q <= '0;
                        bad_q <= '0;
                        if (GOOD_CNT <= 1) begin
                            state_q  <= ST_LOCK;
                            locked_q <= 1'b1;
                            good_q   <= '0;
                        end else begin
                            state_q <= ST_VERIFY;
                            good_q  <= GoodW'(1);
                        end
                    end
                end
                ST_VERIFY: begin
                    if (!hdr_ok_i) begin
                        state_q <= ST_HUNT;
                        good_q  <= '0;
                    end else if (good_q == GoodLast) begin
                        state_q  <= ST_LOCK;
                        locked_q <= 1'b1;
                        good_q   <= '0;
                        win_q    <= '0;
                        bad_q    <= '0;
                    end else begin
                        good_q <= good_q + GoodW'(1);
                    end
                end
                ST_LOCK: begin
                    // Loss of lock wins over the window clear on the same word.
                    if (!hdr_ok_i && bad_q == BadLast) begin
                        state_q  <= ST_HUNT;
                        locked_q <= 1'b0;
                        good_q   <= '0;
                        win_q    <= '0;
                        bad_q    <= '0;
                    end else if (win_q == WinLast) begin
                        win_q <= '0;
                        bad_q <= '0;
                    end else begin
                        win_q <= win_q + WinW'(1);
                        if (!hdr_ok_i) begin
                            bad_q <= bad_q + BadW'(1);
                        end
                    end
                end
                default: begin
                    state_q  <= ST_HUNT;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign locked_o = locked_q;

endmodule

// File: rtl/gearbox_rx_67b.sv
// Interlaken RX gearbox: packs IN_W-bit SERDES data into 67-bit words and slips to word lock.
module gearbox_rx_67b
    import gearbox_pkg::*;
#(
    parameter int unsigned IN_W      = 64,
    parameter int unsigned GOOD_CNT  = 64,
    parameter int unsigned WINDOW    = 64,
    parameter int unsigned BAD_LIMIT = 16
) (
    input  logic              user_clk_i,
    input  logic              reset_i,
    input  logic [IN_W-1:0]   data_in_i,
    output logic [WORD_W-1:0] data_out_o,
    output logic              data_valid_o,
    output logic              header_err_o,
    output logic              locked_o
);

    localparam int unsigned BUF_W  = WORD_W + IN_W - 1;
    localparam int unsigned FILL_W = $clog2(WORD_W + IN_W);

    // Valid bits are right-justified; the oldest one sits at index fill-1.
    logic [BUF_W-1:0]  bits_q, bits_d, ext;
    logic [FILL_W-1:0] fill_q, fill_d, fill_ext, rem;
    logic              slip_pending_q, slip_pending_d;
    logic [IN_W-1:0]   din_eff;
    logic [WORD_W-1:0] cand;
    logic              cand_valid, hdr_ok, slip, fsm_locked;

    logic [WORD_W-1:0] data_out_q;
    logic              data_valid_q, header_err_q;

    always_comb begin
        din_eff = data_in_i;
        if (slip_pending_q) begin
            din_eff[IN_W-1] = 1'b0;
            ext             = (bits_q << (IN_W - 1)) | BUF_W'(din_eff);
            fill_ext        = fill_q + FILL_W'(IN_W - 1);
        end else begin
            ext      = (bits_q << IN_W) | BUF_W'(din_eff);
            fill_ext = fill_q + FILL_W'(IN_W);
        end

        cand_valid = fill_ext >= FILL_W'(WORD_W);
        rem        = fill_ext - FILL_W'(WORD_W);
        cand       = WORD_W'(ext >> rem);
        hdr_ok     = hdr_valid(cand[WORD_W-2 -: 2]);

        bits_d         = ext;
        fill_d         = fill_ext;
        slip_pending_d = 1'b0;
        if (cand_valid) begin
            fill_d = rem;
            if (slip) begin
                if (rem != '0) begin
                    fill_d = rem - FILL_W'(1);
                end else begin
                    slip_pending_d = 1'b1;
                end
            end
        end
    end

    word_lock_fsm #(
        .GOOD_CNT (GOOD_CNT),
        .WINDOW   (WINDOW),
        .BAD_LIMIT(BAD_LIMIT)
    ) u_fsm (
        .clk_i       (user_clk_i),
        .rst_i       (reset_i),
        .cand_valid_i(cand_valid),
        .hdr_ok_i    (hdr_ok),
        .slip_o      (slip),
        .locked_o    (fsm_locked)
    );

    always_ff @(posedge user_clk_i or posedge reset_i) begin
        if (reset_i) begin
            bits_q         <= '0;
            fill_q         <= '0;
            slip_pending_q <= 1'b0;
            data_out_q     <= '0;
            data_valid_q   <= 1'b0;
            header_err_q   <= 1'b0;
        end else begin
            bits_q         <= bits_d;
            fill_q         <= fill_d;
            slip_pending_q <= slip_pending_d;
            // A slip while locked means lock is being lost, so that word gets no strobe.
            data_valid_q   <= cand_valid && fsm_locked && !slip;
            header_err_q   <= cand_valid && !hdr_ok;
            if (cand_valid) begin
                data_out_q <= cand;
            end
        end
    end

    assign data_out_o   = data_out_q;
    assign data_valid_o = data_valid_q;
    assign header_err_o = header_err_q;
    assign locked_o     = fsm_locked;

endmodule

// File: tb/tb_gearbox_rx_67b.sv
// Bench for gearbox_rx_67b: IN_W=64/40/67 instances run side by side against a bit-stream model.
module tb_gearbox_rx_67b;

    localparam int GoodCnt  = 64;
    localparam int Window   = 64;
    localparam int BadLimit = 16;
    localparam int Hunt     = 0;
    localparam int Verify   = 1;
    localparam int Lock     = 2;
    localparam int Msk      = 1023;

    logic        clk   = 1'b0;
    logic [2:0]  rst   = 3'b111;
    logic [63:0] din64 = '0;
    logic [39:0] din40 = '0;
    logic [66:0] din67 = '0;
    logic [66:0] dout64, dout40, dout67;
    logic        dv64, dv40, dv67, err64, err40, err67, lk64, lk40, lk67;

    always #5 clk = ~clk;

    gearbox_rx_67b #(.IN_W(64), .GOOD_CNT(GoodCnt), .WINDOW(Window), .BAD_LIMIT(BadLimit)) u64 (
        .user_clk_i(clk), .reset_i(rst[0]), .data_in_i(din64), .data_out_o(dout64),
        .data_valid_o(dv64), .header_err_o(err64), .locked_o(lk64));
    gearbox_rx_67b #(.IN_W(40), .GOOD_CNT(GoodCnt), .WINDOW(Window), .BAD_LIMIT(BadLimit)) u40 (
        .user_clk_i(clk), .reset_i(rst[1]), .data_in_i(din40), .data_out_o(dout40),
        .data_valid_o(dv40), .header_err_o(err40), .locked_o(lk40));
    gearbox_rx_67b #(.IN_W(67), .GOOD_CNT(GoodCnt), .WINDOW(Window), .BAD_LIMIT(BadLimit)) u67 (
        .user_clk_i(clk), .reset_i(rst[2]), .data_in_i(din67), .data_out_o(dout67),
        .data_valid_o(dv67), .header_err_o(err67), .locked_o(lk67));

    int n_checks = 0;
    int n_fail   = 0;

    // Transmit side: bit stream per instance, plus the words it was built from.
    bit          txb     [3][1024];
    int          txh     [3];
    int          txt     [3];
    logic [66:0] txword  [3][1024];
    int          txw     [3];
    bit          bad_mark[3][1024];

    // Receive model: queue of stream bits with their stream positions.
    bit          rxb  [3][1024];
    int          rxp  [3][1024];
    int          rxh  [3];
    int          rxt  [3];
    bit          spend[3];
    int          st   [3];
    int          good [3];
    int          win  [3];
    int          bad  [3];
    int          words[3];
    int          e_pos[3];
    logic [66:0] e_out[3];
    bit          e_valid[3];
    bit          e_err  [3];
    bit          e_lock [3];

    task automatic check_eq(input string tag, input logic [66:0] got, input logic [66:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int width_of(input int k);
        case (k)
            0:       return 64;
            1:       return 40;
            default: return 67;
        endcase
    endfunction

    task automatic get_obs(input int k, output logic [66:0] o, output logic v, output logic e,
                           output logic l);
        case (k)
            0:       begin o = dout64; v = dv64; e = err64; l = lk64; end
            1:       begin o = dout40; v = dv40; e = err40; l = lk40; end
            default: begin o = dout67; v = dv67; e = err67; l = lk67; end
        endcase
    endtask

    task automatic model_reset(input int k);
        rxh[k] = 0; rxt[k] = 0; spend[k] = 1'b0;
        st[k] = Hunt; good[k] = 0; win[k] = 0; bad[k] = 0; words[k] = 0;
        e_out[k] = '0; e_valid[k] = 1'b0; e_err[k] = 1'b0; e_lock[k] = 1'b0;
    endtask

    task automatic tx_push(input int k, input bit b);
        txb[k][txt[k] & Msk] = b;
        txt[k]++;
    endtask

    task automatic tx_restart(input int k, input int off);
        txh[k] = 0; txt[k] = 0; txw[k] = 0;
        for (int i = 0; i < off; i++) tx_push(k, 1'($urandom_range(0, 1)));
    endtask

    task automatic tx_fill(input int k);
        logic [66:0] w;
        while (txt[k] - txh[k] < 67) begin
            w[31:0]  = $urandom;
            w[63:32] = $urandom;
            w[66]    = 1'($urandom_range(0, 1));
            if (bad_mark[k][txw[k] & Msk]) w[65:64] = ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11;
            else                           w[65:64] = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
            txword[k][txw[k] & Msk] = w;
            txw[k]++;
            for (int b = 66; b >= 0; b--) tx_push(k, w[b]);
        end
    endtask

    // One cycle of the reference: feed W bits, extract at most one word, apply lock rules.
    task automatic model_step(input int k, output logic [66:0] dv);
        int          wdt;
        int          p;
        bit          b;
        bit          ok;
        bit          was_lock;
        bit          slip;
        logic [66:0] w;
        wdt = width_of(k);
        tx_fill(k);
        dv = '0;
        for (int i = 0; i < wdt; i++) begin
            p = txh[k];
            b = txb[k][p & Msk];
            txh[k]++;
            dv[wdt-1-i] = b;
            if (i == 0 && spend[k]) begin
                spend[k] = 1'b0;
            end else begin
                rxb[k][rxt[k] & Msk] = b;
                rxp[k][rxt[k] & Msk] = p;
                rxt[k]++;
            end
        end
        e_valid[k] = 1'b0;
        e_err[k]   = 1'b0;
        if (rxt[k] - rxh[k] >= 67) begin
            for (int j = 0; j < 67; j++) w[66-j] = rxb[k][(rxh[k] + j) & Msk];
            e_pos[k] = rxp[k][rxh[k] & Msk];
            rxh[k] += 67;
            words[k]++;
            e_out[k] = w;
            ok = (w[65:64] == 2'b01) || (w[65:64] == 2'b10);
            e_err[k] = !ok;
            was_lock = (st[k] == Lock);
            slip = 1'b0;
            if (st[k] == Hunt) begin
                if (ok) begin
                    st[k] = Verify; good[k] = 1;
                    if (good[k] >= GoodCnt) begin st[k] = Lock; win[k] = 0; bad[k] = 0; end
                end else begin
                    slip = 1'b1;
                end
            end else if (st[k] == Verify) begin
                if (ok) begin
                    good[k]++;
                    if (good[k] == GoodCnt) begin st[k] = Lock; win[k] = 0; bad[k] = 0; end
                end else begin
                    slip = 1'b1; st[k] = Hunt; good[k] = 0;
                end
            end else begin
                win[k]++;
                if (!ok) bad[k]++;
                if (bad[k] == BadLimit) begin
                    slip = 1'b1; st[k] = Hunt; good[k] = 0; win[k] = 0; bad[k] = 0;
                end else if (win[k] == Window) begin
                    win[k] = 0; bad[k] = 0;
                end
            end
            e_valid[k] = was_lock && (st[k] == Lock);
            if (slip) begin
                if (rxt[k] > rxh[k]) rxh[k]++;
                else                 spend[k] = 1'b1;
            end
        end
        e_lock[k] = (st[k] == Lock);
    endtask

    // Advance one clock; instances in rmask are reset during this cycle instead of fed.
    task automatic step(input logic [2:0] rmask);
        logic [66:0] dv;
        logic [66:0] o;
        logic        v, e, l;
        for (int k = 0; k < 3; k++) begin
            if (!rmask[k]) begin
                model_step(k, dv);
                case (k)
                    0:       din64 = dv[63:0];
                    1:       din40 = dv[39:0];
                    default: din67 = dv;
                endcase
            end
        end
        if (rmask != 3'b000) begin
            rst = rst | rmask;
            #1;
            for (int k = 0; k < 3; k++) begin
                if (rmask[k]) begin
                    get_obs(k, o, v, e, l);
                    check_eq($sformatf("u%0d.rst_data_out", width_of(k)), o, '0);
                    check_eq($sformatf("u%0d.rst_data_valid", width_of(k)), 67'(v), '0);
                    check_eq($sformatf("u%0d.rst_header_err", width_of(k)), 67'(e), '0);
                    check_eq($sformatf("u%0d.rst_locked", width_of(k)), 67'(l), '0);
                    model_reset(k);
                end
            end
        end
        @(posedge clk);
        #1;
        rst = rst & ~rmask;
        for (int k = 0; k < 3; k++) begin
            get_obs(k, o, v, e, l);
            check_eq($sformatf("u%0d.data_out", width_of(k)), o, e_out[k]);
            check_eq($sformatf("u%0d.data_valid", width_of(k)), 67'(v), 67'(e_valid[k]));
            check_eq($sformatf("u%0d.header_err", width_of(k)), 67'(e), 67'(e_err[k]));
            check_eq($sformatf("u%0d.locked", width_of(k)), 67'(l), 67'(e_lock[k]));
        end
    endtask

    initial begin
        int  lock_word, first_valid, drop_word, errs_locked, tp_cyc, tp_cnt;
        int  herr, last_err_word, rel;
        bit  prev_lock, drop_err;

        for (int k = 0; k < 3; k++) begin
            model_reset(k);
            for (int i = 0; i <= Msk; i++) bad_mark[k][i] = 1'b0;
        end
        #2;
        step(3'b111);

        // Aligned stream on u64 with error bursts; random offsets on the other widths.
        tx_restart(0, 0);
        for (int i = 74; i <= 88; i++) bad_mark[0][i] = 1'b1;
        bad_mark[0][150] = 1'b1;
        for (int i = 200; i <= 215; i++) bad_mark[0][i] = 1'b1;
        tx_restart(1, int'($urandom_range(1, 66)));
        tx_restart(2, int'($urandom_range(1, 66)));

        lock_word = -1; first_valid = -1; drop_word = -1; drop_err = 1'b0;
        errs_locked = 0; tp_cyc = 0; tp_cnt = 0;
        for (int c = 0; c < 3000 && words[0] < 230; c++) begin
            prev_lock = lk64;
            step(3'b000);
            if (lk64 && lock_word < 0) lock_word = words[0];
            if (dv64 && first_valid < 0) first_valid = words[0];
            if (first_valid >= 0 && tp_cyc < 67) begin
                tp_cyc++;
                tp_cnt += int'(dv64);
            end
            if (prev_lock && lk64 && err64) errs_locked++;
            if (prev_lock && !lk64 && drop_word < 0) begin
                drop_word = words[0];
                drop_err  = err64;
            end
        end
        check_eq("u64.lock_word", 67'(lock_word), 67'(64));
        check_eq("u64.first_valid_word", 67'(first_valid), 67'(65));
        check_eq("u64.valid_per_67_cycles", 67'(tp_cnt), 67'(64));
        check_eq("u64.errs_while_locked", 67'(errs_locked), 67'(31));
        check_eq("u64.drop_word", 67'(drop_word), 67'(216));
        check_eq("u64.drop_with_header_err", 67'(drop_err), 67'(1));

        // Stream shifted by 13 bits: exactly 13 slips, then 64 words to lock.
        step(3'b001);
        for (int i = 0; i <= Msk; i++) bad_mark[0][i] = 1'b0;
        tx_restart(0, 13);
        herr = 0; last_err_word = 0; lock_word = -1;
        for (int c = 0; c < 3000 && !lk64; c++) begin
            step(3'b000);
            if (err64) begin herr++; last_err_word = words[0]; end
            if (lk64) lock_word = words[0];
        end
        check_eq("u64.shift13_locked", 67'(lk64), 67'(1));
        check_eq("u64.shift13_slips", 67'(herr), 67'(13));
        check_eq("u64.shift13_words_to_lock", 67'(lock_word - last_err_word), 67'(64));
        for (int c = 0; c < 12; c++) begin
            step(3'b000);
            if (dv64) begin
                rel = e_pos[0] - 13;
                check_eq("u64.word_boundary", 67'(rel % 67), 67'(0));
                check_eq("u64.tx_word", dout64, txword[0][(rel / 67) & Msk]);
            end
        end

        // Reset pulse while locked with a partial word buffered, then relock.
        check_eq("u64.locked_before_rst", 67'(lk64), 67'(1));
        step(3'b001);
        tx_restart(0, 0);
        lock_word = -1;
        for (int c = 0; c < 3000 && !lk64; c++) begin
            step(3'b000);
            if (lk64) lock_word = words[0];
        end
        check_eq("u64.relock_word", 67'(lock_word), 67'(64));

        // Other widths: lock from a random offset, then IN_W=67 yields a word every cycle.
        for (int c = 0; c < 8000 && !(lk40 && lk67); c++) step(3'b000);
        check_eq("u40.locked", 67'(lk40), 67'(1));
        check_eq("u67.locked", 67'(lk67), 67'(1));
        tp_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            step(3'b000);
            tp_cnt += int'(dv67);
        end
        check_eq("u67.words_per_20_cycles", 67'(tp_cnt), 67'(20));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
